// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution tile loader.
package conv_pkg;

  localparam int         DEFAULT_WIDTH_IN = 10;
  localparam logic [3:0] CFG_BIAS_ADDR    = 4'd9;

  typedef logic [31:0] pixel_t;
  typedef logic [15:0] coef_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/tile_bank.sv
// One tile buffer: NPIX pixel registers plus a FILL/FULL flag.
module tile_bank
  import conv_pkg::*;
#(
  parameter  int NPIX  = DEFAULT_WIDTH_IN * DEFAULT_WIDTH_IN,
  localparam int PTR_W = $clog2(NPIX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      widx_i,
  input  logic [31:0]           wdata_i,
  input  logic                  set_full_i,
  input  logic                  clr_full_i,
  output logic                  full_o,
  output logic [NPIX-1:0][31:0] data_o
);

  bank_state_e            state_q;
  pixel_t [NPIX-1:0]      mem_q;

  // NOTE: the pixel array is reset too, because it drives pixels_out directly
  // through the present-bank mux and those outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      state_q <= FILL;
    end else begin
      if (we_i) mem_q[widx_i] <= wdata_i;
      if (set_full_i)      state_q <= FULL;
      else if (clr_full_i) state_q <= FILL;
    end
  end

  assign full_o = (state_q == FULL);
  assign data_o = mem_q;

endmodule

// File: rtl/conv_tile_loader.sv
// Assembles a raster pixel stream into ping-pong tiles for the convolution
// array and holds its mask/bias coefficients.
module conv_tile_loader
  import conv_pkg::*;
#(
  parameter  int WIDTH_IN = DEFAULT_WIDTH_IN,
  localparam int NPIX     = WIDTH_IN * WIDTH_IN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [NPIX-1:0][31:0] pixels_out,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [15:0]           cfg_data,
  output logic [8:0][15:0]      mask,
  output logic [15:0]           bias,
  output logic                  cfg_err
);

  localparam int               PTR_W    = $clog2(NPIX);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NPIX - 1);

  logic                  fill_ptr_q, fill_ptr_d;
  logic                  pres_ptr_q, pres_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, wr_idx;
  logic [1:0]            full, full_d, set_full, clr_full, bank_we;
  logic                  accept, complete, handshake, cfg_ok;
  logic [NPIX-1:0][31:0] bank_data [2];
  coef_t [8:0]           mask_q;
  coef_t                 bias_q;
  logic                  cfg_err_q;

  assign pix_ready  = ~full[fill_ptr_q];
  assign tile_valid = full[pres_ptr_q];
  assign pixels_out = bank_data[pres_ptr_q];

  // NOTE: every always_comb output is given a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept    = pix_valid && pix_ready;
    handshake = tile_valid && tile_ready;
    complete  = accept && !pix_sof && (wr_ptr_q == LAST_IDX);
    wr_idx    = pix_sof ? '0 : wr_ptr_q;

    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      if (pix_sof)       wr_ptr_d = PTR_W'(1);
      else if (complete) wr_ptr_d = '0;
      else               wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    bank_we              = '0;
    bank_we[fill_ptr_q]  = accept;
    set_full             = '0;
    set_full[fill_ptr_q] = complete;
    clr_full             = '0;
    clr_full[pres_ptr_q] = handshake;
    full_d               = (full & ~clr_full) | set_full;

    // Fill moves on once its bank is full and the other is free; present
    // hands over once its bank is empty and the other holds a tile. Judging
    // on next-state flags lets a completion and a handshake share one edge.
    fill_ptr_d = (full_d[fill_ptr_q] && !full_d[~fill_ptr_q]) ? ~fill_ptr_q : fill_ptr_q;
    pres_ptr_d = (!full_d[pres_ptr_q] && full_d[~pres_ptr_q]) ? ~pres_ptr_q : pres_ptr_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(.NPIX(NPIX)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (bank_we[b]),
      .widx_i     (wr_idx),
      .wdata_i    (pix_data),
      .set_full_i (set_full[b]),
      .clr_full_i (clr_full[b]),
      .full_o     (full[b]),
      .data_o     (bank_data[b])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr_q <= 1'b0;
      pres_ptr_q <= 1'b1;
      wr_ptr_q   <= '0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      pres_ptr_q <= pres_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Writes are refused while a tile is presented so the array sees stable coefficients.
  assign cfg_ok = cfg_we && !tile_valid && (cfg_addr <= CFG_BIAS_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      bias_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        if (cfg_addr == CFG_BIAS_ADDR) bias_q <= cfg_data;
        else                           mask_q[cfg_addr] <= cfg_data;
      end
    end
  end

  assign mask    = mask_q;
  assign bias    = bias_q;
  assign cfg_err = cfg_err_q;

endmodule
